// File: rtl/gearbox_pkg.sv
// Shared definitions for the width-converter family (wide_to_narrow and
// its siblings): legal ratio bounds and the word-count field width helper.
package gearbox_pkg;

  // Smallest and largest number of words per wide beat any converter supports.
  localparam int RATIO_MIN = 2;
  localparam int RATIO_MAX = 16;

  // Width of a field that must hold a word count from 0 up to ratio inclusive.
  function automatic int cnt_w(input int ratio);
    return $clog2(ratio + 1);
  endfunction

endpackage : gearbox_pkg

// File: rtl/wide_to_narrow.sv
// Width down-converter: takes one wide beat of up to RATIO words and
// streams the valid words out one per cycle. Supports a variable word
// count per beat, selectable word order, a last-word marker and a
// synchronous flush.
//
// Storage is a single RATIO-word register that is loaded whole and then
// shifted one word per output transfer, so the outgoing word is always
// at a fixed end of the register (bottom for LSW-first, top for
// MSW-first). For MSW-first the beat is top-aligned on load so the
// highest valid word sits in the output slot.
module wide_to_narrow
  import gearbox_pkg::*;
#(
  parameter int WORD_LEN  = 33,
  parameter int RATIO     = 4,
  parameter bit MSW_FIRST = 1'b0,
  parameter int CW        = cnt_w(RATIO)
) (
  input  logic                      clk,
  input  logic                      arst,
  input  logic                      sclr,
  input  logic [RATIO*WORD_LEN-1:0] din,
  input  logic [CW-1:0]             din_words,
  input  logic                      din_valid,
  output logic                      din_ready,
  output logic [WORD_LEN-1:0]       dout,
  output logic                      dout_valid,
  input  logic                      dout_ready,
  output logic                      dout_last,
  output logic [CW-1:0]             holding
);

  localparam int DW = RATIO * WORD_LEN;
  localparam logic [CW-1:0] RATIO_C = CW'(RATIO);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  // Refuse to elaborate with a ratio the counter and alignment logic
  // were not sized for.
  if (RATIO < RATIO_MIN || RATIO > RATIO_MAX) begin : g_bad_ratio
    $error("wide_to_narrow: RATIO=%0d outside %0d..%0d", RATIO, RATIO_MIN, RATIO_MAX);
  end

  logic [DW-1:0] storage_q, storage_d;
  logic [CW-1:0] holding_q, holding_d;

  logic [CW-1:0] k_clamp;
  logic [DW-1:0] load_w;
  logic          in_xfer;
  logic          out_xfer;

  // Beat counts above RATIO are treated as a full beat.
  always_comb begin
    k_clamp = (din_words > RATIO_C) ? RATIO_C : din_words;
  end

  // Align an incoming beat so the first word to send sits in the output slot.
  always_comb begin : load_align
    int src;
    load_w = '0;
    src    = 0;
    if (!MSW_FIRST) begin
      load_w = din;
    end else begin
      for (int j = 0; j < RATIO; j++) begin
        src = j - (RATIO - int'(k_clamp));
        if (src >= 0) begin
          load_w[j*WORD_LEN +: WORD_LEN] = din[src*WORD_LEN +: WORD_LEN];
        end
      end
    end
  end

  // Accept a new beat when empty, or when the last held word leaves this
  // cycle; this lets beats follow each other without a bubble.
  always_comb begin
    din_ready = !sclr && ((holding_q == '0) || ((holding_q == ONE_C) && dout_ready));
    in_xfer   = din_valid && din_ready;
    out_xfer  = dout_valid && dout_ready;
  end

  // Next occupancy and storage: flush beats load beats shift.
  always_comb begin
    holding_d = holding_q;
    storage_d = storage_q;
    if (sclr) begin
      holding_d = '0;
      storage_d = '0;
    end else if (in_xfer) begin
      // A load at holding==1 also retires the final old word; the new
      // beat simply overwrites it.
      holding_d = k_clamp;
      storage_d = load_w;
    end else if (out_xfer) begin
      holding_d = holding_q - ONE_C;
      if (!MSW_FIRST) begin
        storage_d = storage_q >> WORD_LEN;
      end else begin
        storage_d = storage_q << WORD_LEN;
      end
    end
  end

  // Occupancy and storage registers; reset discards any beat in flight.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      holding_q <= '0;
      storage_q <= '0;
    end else begin
      holding_q <= holding_d;
      storage_q <= storage_d;
    end
  end

  // Outputs are decoded purely from the registers.
  always_comb begin
    if (!MSW_FIRST) begin
      dout = storage_q[WORD_LEN-1:0];
    end else begin
      dout = storage_q[DW-1 -: WORD_LEN];
    end
    dout_valid = (holding_q != '0);
    dout_last  = (holding_q == ONE_C);
    holding    = holding_q;
  end

endmodule : wide_to_narrow

// File: tb/tb_wide_to_narrow.sv
// Bench for wide_to_narrow: drives an LSW-first and an MSW-first instance
// with the same stimulus and compares both against a word-queue model.
module tb_wide_to_narrow;

  localparam int WL = 8;
  localparam int R  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          arst = 1'b1;
  logic          sclr = 1'b0;
  logic [R*WL-1:0] din = '0;
  logic [CW-1:0] din_words = '0;
  logic          din_valid = 1'b0;
  logic          dout_ready = 1'b0;

  logic          rdy0, rdy1, v0, v1, l0, l1;
  logic [WL-1:0] d0, d1;
  logic [CW-1:0] h0, h1;

  int n_chk  = 0;
  int n_pass = 0;

  // Expected word streams per instance; last flag is implied by size==1.
  logic [WL-1:0] q0[$];
  logic [WL-1:0] q1[$];
  bit            clean = 1'b1;

  always #5 clk = ~clk;

  wide_to_narrow #(.WORD_LEN(WL), .RATIO(R), .MSW_FIRST(1'b0)) u_lsw (
    .clk(clk), .arst(arst), .sclr(sclr), .din(din), .din_words(din_words),
    .din_valid(din_valid), .din_ready(rdy0), .dout(d0), .dout_valid(v0),
    .dout_ready(dout_ready), .dout_last(l0), .holding(h0));

  wide_to_narrow #(.WORD_LEN(WL), .RATIO(R), .MSW_FIRST(1'b1)) u_msw (
    .clk(clk), .arst(arst), .sclr(sclr), .din(din), .din_words(din_words),
    .din_valid(din_valid), .din_ready(rdy1), .dout(d1), .dout_valid(v1),
    .dout_ready(dout_ready), .dout_last(l1), .holding(h1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic chk_dut(input string nm, input logic [WL-1:0] q[$], input logic rdy_exp,
                         input logic rdy, input logic [WL-1:0] d, input logic v,
                         input logic l, input logic [CW-1:0] h);
    chk({nm, ".din_ready"}, 32'(rdy), 32'(rdy_exp));
    chk({nm, ".holding"}, 32'(h), q.size());
    chk({nm, ".dout_valid"}, 32'(v), 32'(q.size() != 0));
    chk({nm, ".dout_last"}, 32'(l), 32'(q.size() == 1));
    if (q.size() != 0) chk({nm, ".dout"}, 32'(d), 32'(q[0]));
    else if (clean)    chk({nm, ".dout_idle"}, 32'(d), 32'h0);
  endtask

  // Inputs are already set (one time unit after the edge). Check mid-cycle,
  // then advance the model across the coming edge.
  task automatic step();
    bit exp_rdy;
    int k;
    #4;
    exp_rdy = !sclr && (q0.size() == 0 || (q0.size() == 1 && dout_ready));
    chk_dut("lsw", q0, exp_rdy, rdy0, d0, v0, l0, h0);
    chk_dut("msw", q1, exp_rdy, rdy1, d1, v1, l1, h1);
    if (sclr) begin
      q0.delete(); q1.delete(); clean = 1'b1;
    end else begin
      if (q0.size() != 0 && dout_ready) begin
        void'(q0.pop_front());
        void'(q1.pop_front());
      end
      if (din_valid && exp_rdy) begin
        k = (int'(din_words) > R) ? R : int'(din_words);
        for (int i = 0; i < k; i++) q0.push_back(din[i*WL +: WL]);
        for (int i = k - 1; i >= 0; i--) q1.push_back(din[i*WL +: WL]);
        clean = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [R*WL-1:0] d, input int k);
    din = d; din_words = CW'(k); din_valid = 1'b1;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear at once.
  task automatic do_arst();
    #1;
    arst = 1'b1;
    #1;
    q0.delete(); q1.delete(); clean = 1'b1;
    chk("arst.holding_lsw", 32'(h0), 32'h0);
    chk("arst.holding_msw", 32'(h1), 32'h0);
    chk("arst.valid_lsw", 32'(v0), 32'h0);
    chk("arst.valid_msw", 32'(v1), 32'h0);
    chk("arst.dout_msw", 32'(d1), 32'h0);
    @(posedge clk);
    #1;
    arst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    arst = 1'b0;
    step();

    // Full 4-word beat, downstream always ready.
    dout_ready = 1'b1;
    beat(32'h44332211, 4);
    step();
    din_valid = 1'b0;
    repeat (5) step();

    // 3-word beat: LSW gives 11,22,33; MSW gives 33,22,11.
    beat(32'h00332211, 3);
    step();
    din_valid = 1'b0;
    repeat (4) step();

    // Back-to-back 2-word beats.
    for (int i = 0; i < 10; i++) begin
      beat($urandom(), 2);
      step();
    end
    din_valid = 1'b0;
    repeat (3) step();

    // Empty beat then single-word beat.
    beat(32'h12345678, 0);
    step();
    beat(32'h9ABCDEAA, 1);
    step();
    din_valid = 1'b0;
    repeat (3) step();

    // Stall pattern 1,0,0,1 through a 4-word beat.
    beat(32'hD4C3B2A1, 4);
    step();
    din_valid = 1'b0;
    dout_ready = 1'b1; step();
    dout_ready = 1'b0; step();
    dout_ready = 1'b0; step();
    dout_ready = 1'b1; step();
    repeat (3) step();

    // Flush with three words held.
    beat(32'h87654321, 4);
    step();
    din_valid = 1'b0;
    dout_ready = 1'b1; step();
    dout_ready = 1'b0; step();
    chk("pre_sclr.holding", 32'(h0), 32'h3);
    sclr = 1'b1;
    beat(32'hFFFFFFFF, 4);
    step();
    sclr = 1'b0; din_valid = 1'b0;
    repeat (2) step();

    // Reset with two words held.
    dout_ready = 1'b1;
    beat(32'h0F0E0D0C, 4);
    step();
    din_valid = 1'b0;
    step();
    step();
    chk("pre_arst.holding", 32'(h1), 32'h2);
    do_arst();
    repeat (3) step();

    // Randomized traffic, including clamped counts and occasional flushes.
    for (int c = 0; c < 2000; c++) begin
      din        = $urandom();
      din_words  = ($urandom_range(0, 9) == 0) ? CW'($urandom_range(5, 7)) : CW'($urandom_range(0, 4));
      din_valid  = ($urandom_range(0, 3) != 0);
      dout_ready = ($urandom_range(0, 3) != 0);
      sclr       = ($urandom_range(0, 39) == 0);
      step();
    end
    sclr = 1'b0; din_valid = 1'b0; dout_ready = 1'b1;
    repeat (6) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_wide_to_narrow
